// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Stretches short or level triggers into human-visible pulses, one independent
// channel per bit. A shared prescaler produces a sample tick every
// SAMPLE_CNT_MAX clocks. Each channel holds its output high for HOLD_CNT_MAX
// ticks and then forces it low for at least GAP_CNT_MAX ticks. A trigger that
// arrives during the low gap is remembered, so the next pulse starts as soon
// as the gap ends.
//
// Parameters:
//   WIDTH          number of independent channels
//   SAMPLE_CNT_MAX clock cycles per sample tick
//   HOLD_CNT_MAX   sample ticks the output is held high per pulse
//   GAP_CNT_MAX    minimum sample ticks low between pulses (0 = no gap)
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   pulse_in       per-channel trigger (single-cycle or level)
//   stretched_out  per-channel stretched pulse, registered
//   busy           per-channel "not idle or trigger pending", registered
//
// Build option:
//   PULSE_STRETCHER_RETRIGGER_EN  when defined, a trigger while the output is
//                                 high reloads the hold counter and extends
//                                 the pulse. When undefined, such a trigger
//                                 is ignored.
//
// Handshake: none. pulse_in is sampled on every rising edge. The outputs are
// derived from the next-state value and registered, so they follow a trigger
// edge by exactly one cycle.
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int HOLD_CNT_MAX   = 200,
    parameter int GAP_CNT_MAX    = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pulse_in,
    output logic [WIDTH-1:0] stretched_out,
    output logic [WIDTH-1:0] busy
);

    localparam int PW      = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int CNT_MAX = (HOLD_CNT_MAX > GAP_CNT_MAX) ? HOLD_CNT_MAX : GAP_CNT_MAX;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CNT_MAX);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    // Shared prescaler. The tick is high for the single cycle at the top count.
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          pending;
        logic          pending_nxt;
        logic          out_q;
        logic          busy_q;

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            pending_nxt = pending;
            case (state)
                ST_IDLE: begin
                    if (pulse_in[i]) begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
                ST_ACTIVE: begin
                    // A reload wins over a decrement that lands in the same cycle.
                    if (RETRIGGER && pulse_in[i]) begin
                        cnt_nxt = HOLD_LOAD;
                    end else if (tick) begin
                        // "<= 1" rather than "== 1" so a zero count can never wrap.
                        if (cnt <= CNT_ONE) begin
                            if (GAP_CNT_MAX == 0) begin
                                state_nxt = ST_IDLE;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = ST_GAP;
                                cnt_nxt   = GAP_LOAD;
                            end
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (pulse_in[i]) begin
                        pending_nxt = 1'b1;
                    end
                    if (tick) begin
                        if (cnt <= CNT_ONE) begin
                            // A trigger arriving on the very last gap edge is
                            // honoured like one that arrived earlier in the gap.
                            if (pending || pulse_in[i]) begin
                                state_nxt = ST_ACTIVE;
                                cnt_nxt   = HOLD_LOAD;
                            end else begin
                                state_nxt = ST_IDLE;
                                cnt_nxt   = '0;
                            end
                            pending_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                pending <= pending_nxt;
                out_q   <= (state_nxt == ST_ACTIVE);
                busy_q  <= (state_nxt != ST_IDLE) || pending_nxt;
            end
        end

        assign stretched_out[i] = out_q;
        assign busy[i]          = busy_q;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Bench for pulse_stretcher with WIDTH=2, SAMPLE_CNT_MAX=4, HOLD_CNT_MAX=3 and
// GAP_CNT_MAX=2. A cycle-exact vector table covers the single pulse, the
// pending trigger during the gap, and two channels triggered three cycles
// apart. Hand-written sequences cover the held-high trigger, the retrigger,
// the asynchronous reset and the first trigger after reset.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

    localparam int WIDTH  = 2;
    localparam int SAMPLE = 4;
    localparam int HOLD   = 3;
    localparam int GAP    = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] pulse_in;
    logic [WIDTH-1:0] stretched_out;
    logic [WIDTH-1:0] busy;

    int n_checks = 0;
    int n_pass   = 0;

    pulse_stretcher #(
        .WIDTH         (WIDTH),
        .SAMPLE_CNT_MAX(SAMPLE),
        .HOLD_CNT_MAX  (HOLD),
        .GAP_CNT_MAX   (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .stretched_out(stretched_out),
        .busy         (busy)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] pulse;
        logic [1:0] exp_out;
        logic [1:0] exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int n, input logic [1:0] p, input logic [1:0] o,
                           input logic [1:0] b);
        vec_t v;
        v.pulse    = p;
        v.exp_out  = o;
        v.exp_busy = b;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Advance one rising edge and settle past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic samp[70];
        int   run_len;
        int   high_runs;
        logic run_val;
        int   hi_len;
        int   extra;
        logic fell;
        logic prev;
        int   exp_lo;
        int   exp_hi;
        int   waited;

        rst_n    = 1'b0;
        pulse_in = '0;

        // Reset state
        repeat (3) cyc();
        chk("reset_out", int'(stretched_out), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Vector table. Vector k is driven before edge Ek after reset release.
        // The prescaler starts at 0, so the ticks land on E4, E8, E12, ...
        // Single pulse on ch0 at E2.
        add_vec(1,  2'b00, 2'b00, 2'b00);
        add_vec(1,  2'b01, 2'b01, 2'b01);
        add_vec(9,  2'b00, 2'b01, 2'b01);   // E3..E11 high, 10 cycles total
        add_vec(8,  2'b00, 2'b00, 2'b01);   // E12..E19 gap
        add_vec(3,  2'b00, 2'b00, 2'b00);   // E20..E22 idle
        // ch0 pulse at E23; two triggers during the gap collapse into one.
        add_vec(1,  2'b01, 2'b01, 2'b01);
        add_vec(8,  2'b00, 2'b01, 2'b01);   // E24..E31
        add_vec(2,  2'b00, 2'b00, 2'b01);   // E32..E33 gap
        add_vec(2,  2'b01, 2'b00, 2'b01);   // E34..E35 triggers in gap
        add_vec(4,  2'b00, 2'b00, 2'b01);   // E36..E39
        add_vec(12, 2'b00, 2'b01, 2'b01);   // E40..E51 pending pulse
        add_vec(8,  2'b00, 2'b00, 2'b01);   // E52..E59 gap
        add_vec(5,  2'b00, 2'b00, 2'b00);   // E60..E64 no extra pulse
        // ch1 at E65, ch0 at E68 (on a tick: counter must start at 3).
        add_vec(1,  2'b10, 2'b10, 2'b10);
        add_vec(2,  2'b00, 2'b10, 2'b10);
        add_vec(1,  2'b01, 2'b11, 2'b11);
        add_vec(7,  2'b00, 2'b11, 2'b11);   // E69..E75
        add_vec(4,  2'b00, 2'b01, 2'b11);   // E76..E79
        add_vec(4,  2'b00, 2'b00, 2'b11);   // E80..E83
        add_vec(4,  2'b00, 2'b00, 2'b01);   // E84..E87
        add_vec(3,  2'b00, 2'b00, 2'b00);   // E88..E90

        for (int k = 0; k < vecs.size(); k++) begin
            pulse_in = vecs[k].pulse;
            cyc();
            chk($sformatf("vec%0d_out", k + 1), int'(stretched_out), int'(vecs[k].exp_out));
            chk($sformatf("vec%0d_busy", k + 1), int'(busy), int'(vecs[k].exp_busy));
        end

        // Held-high trigger: alternating high/low periods, never stuck high.
        for (int c = 0; c < 70; c++) begin
            pulse_in = (c < 40) ? 2'b01 : 2'b00;
            cyc();
            samp[c] = stretched_out[0];
        end
        chk("hold_first_rise", int'(samp[0]), 1);
        high_runs = 0;
        run_val   = samp[0];
        run_len   = 1;
        for (int c = 1; c < 70; c++) begin
            if (samp[c] == run_val) begin
                run_len++;
            end else begin
                if (run_val) begin
                    high_runs++;
                    chk_range("hold_high_len", run_len, 9, 12);
                end else begin
                    chk_range("hold_low_len", run_len, 5, 8);
                end
                run_val = samp[c];
                run_len = 1;
            end
        end
        chk("hold_ends_low", int'(run_val), 0);
        chk("hold_high_runs", high_runs, 3);
        chk("hold_drained", int'(busy), 0);

        // Retrigger six cycles into the high period.
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        exp_lo = 15;
        exp_hi = 18;
`else
        exp_lo = 9;
        exp_hi = 12;
`endif
        pulse_in = 2'b01;
        cyc();
        pulse_in = 2'b00;
        chk("retrig_rise", int'(stretched_out[0]), 1);
        hi_len = stretched_out[0] ? 1 : 0;
        fell   = 1'b0;
        extra  = 0;
        prev   = stretched_out[0];
        for (int c = 1; c <= 50; c++) begin
            pulse_in[0] = (c == 6);
            cyc();
            if (!fell) begin
                if (stretched_out[0]) hi_len++;
                else fell = 1'b1;
            end else if (stretched_out[0] && !prev) begin
                extra++;
            end
            prev = stretched_out[0];
        end
        pulse_in = 2'b00;
        chk_range("retrig_high_len", hi_len, exp_lo, exp_hi);
        chk("retrig_extra_pulses", extra, 0);
        chk("retrig_idle", int'(busy), 0);

        // Reset mid-ACTIVE: outputs clear before the next clock edge.
        pulse_in = 2'b11;
        cyc();
        pulse_in = 2'b00;
        repeat (3) cyc();
        chk("pre_reset_out", int'(stretched_out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", int'(stretched_out), 0);
        chk("async_reset_busy", int'(busy), 0);
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            chk("post_reset_quiet", int'({stretched_out, busy}), 0);
        end

        // Reset mid-GAP.
        pulse_in = 2'b01;
        cyc();
        pulse_in = 2'b00;
        waited = 0;
        while (stretched_out[0] && waited < 20) begin
            cyc();
            waited++;
        end
        chk("gap_reached", int'(stretched_out[0]), 0);
        chk("gap_busy", int'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("gap_reset_busy", int'(busy), 0);
        cyc();

        // First trigger after reset release is taken on the first edge.
        rst_n    = 1'b1;
        pulse_in = 2'b01;
        cyc();
        pulse_in = 2'b00;
        chk("first_trig_out", int'(stretched_out), 1);
        chk("first_trig_busy", int'(busy), 1);
        waited = 0;
        while (busy != 0 && waited < 40) begin
            cyc();
            waited++;
        end
        chk("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
